memory_access: RTL

MEMORY_ACCESS -- requirements
Module: memory_access

---
 rtl/memory_access.sv | 135 +++++++++++++
 1 files changed

// File: rtl/memory_access.sv
// Memory-access pipeline stage: big-endian byte-lane data RAM with a synchronous read,
// load extension, misalignment detection and registered pass-through of ALU/WB/PC.
module memory_access #(
  parameter int unsigned NB_REG  = 32,
  parameter int unsigned NB_MEM  = 5,
  parameter int unsigned NB_WB   = 8,
  parameter int unsigned NB_ADDR = 10
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  input  logic [NB_REG-1:0] i_alu,
  input  logic [NB_REG-1:0] i_b,
  input  logic [NB_MEM-1:0] i_mem,
  input  logic [NB_WB-1:0]  i_wb,
  input  logic [NB_REG-1:0] i_pc,
  output logic [NB_REG-1:0] o_read_data,
  output logic [NB_REG-1:0] o_alu,
  output logic [NB_WB-1:0]  o_wb,
  output logic [NB_REG-1:0] o_pc,
  output logic              o_misaligned,
  output logic              o_error
);

  localparam int unsigned Depth = 2 ** NB_ADDR;

  logic [NB_REG-1:0]  ram_q [Depth];
  logic [NB_REG-1:0]  word_q;
  logic [NB_REG-1:0]  alu_q, pc_q;
  logic [NB_WB-1:0]   wb_q;
  logic               mis_q, err_q, rd_q, uns_q;
  logic [1:0]         size_q, off_q;

  logic               mem_rd, mem_wr, uns, is_byte, is_half, misal, advance, wr_en, rd_en;
  logic [1:0]         size, off;
  logic [NB_ADDR-1:0] addr;
  logic [3:0]         be;
  logic [NB_REG-1:0]  wdata;

  always_comb begin
    mem_rd  = i_mem[4];
    mem_wr  = i_mem[3];
    size    = i_mem[2:1];
    uns     = i_mem[0];
    off     = i_alu[1:0];
    addr    = i_alu[NB_ADDR+1:2];
    is_byte = (size == 2'b00);
    is_half = (size == 2'b01);
    misal   = (mem_rd | mem_wr) &
              ((is_half & off[0]) | (!is_byte && !is_half && off != 2'b00));
    advance = i_valid & ~i_reset;
    wr_en   = advance & mem_wr & ~misal;
    rd_en   = mem_rd & ~mem_wr & ~misal;
    wdata   = i_b;
    be      = 4'b0000;
    // Lane i covers byte offset i, counted from the MSB (big-endian).
    for (int i = 0; i < 4; i++) begin
      if (is_byte) begin
        be[i] = (off == 2'(i));
        wdata[NB_REG-1-8*i -: 8] = i_b[7:0];
      end else if (is_half) begin
        be[i] = (off[1] == ((i / 2) != 0));
        wdata[NB_REG-1-8*i -: 8] = ((i % 2) != 0) ? i_b[7:0] : i_b[15:8];
      end else begin
        be[i] = 1'b1;
      end
    end
  end

  // RAM has no reset so its contents survive i_reset.
  always_ff @(posedge i_clock) begin
    if (advance && rd_en) begin
      word_q <= ram_q[addr];
    end
    for (int i = 0; i < 4; i++) begin
      if (wr_en && be[i]) begin
        ram_q[addr][NB_REG-1-8*i -: 8] <= wdata[NB_REG-1-8*i -: 8];
      end
    end
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      alu_q  <= '0;
      wb_q   <= '0;
      pc_q   <= '0;
      mis_q  <= 1'b0;
      err_q  <= 1'b0;
      rd_q   <= 1'b0;
      uns_q  <= 1'b0;
      size_q <= 2'b00;
      off_q  <= 2'b00;
    end else if (i_valid) begin
      alu_q  <= i_alu;
      wb_q   <= i_wb;
      pc_q   <= i_pc;
      mis_q  <= misal;
      err_q  <= err_q | misal;
      rd_q   <= rd_en;
      uns_q  <= uns;
      size_q <= size;
      off_q  <= off;
    end
  end

  logic [7:0]  byte_v;
  logic [15:0] half_v;

  always_comb begin
    unique case (off_q)
      2'd0:    byte_v = word_q[NB_REG-1  -: 8];
      2'd1:    byte_v = word_q[NB_REG-9  -: 8];
      2'd2:    byte_v = word_q[NB_REG-17 -: 8];
      default: byte_v = word_q[NB_REG-25 -: 8];
    endcase
    half_v = off_q[1] ? word_q[NB_REG-17 -: 16] : word_q[NB_REG-1 -: 16];
    o_read_data = '0;
    if (rd_q) begin
      if (size_q == 2'b00) begin
        o_read_data = {{(NB_REG-8){~uns_q & byte_v[7]}}, byte_v};
      end else if (size_q == 2'b01) begin
        o_read_data = {{(NB_REG-16){~uns_q & half_v[15]}}, half_v};
      end else begin
        o_read_data = word_q;
      end
    end
  end

  assign o_alu        = alu_q;
  assign o_wb         = wb_q;
  assign o_pc         = pc_q;
  assign o_misaligned = mis_q;
  assign o_error      = err_q;

endmodule
